// File: rtl/param_ram.sv
// Single-port word RAM with a fixed request-to-response latency.
// Memory is zero-filled by a one-word-per-cycle sweep after every reset.
module param_ram #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              response,
  output logic [DATA_W-1:0] out
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam int unsigned WaitLoad = (LATENCY > 1) ? LATENCY - 2 : 0;
  localparam int unsigned WaitW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {StInit, StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   init_cnt_q, init_cnt_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [IdxW-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] out_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              enter_resp;
  logic              mem_we;
  logic [IdxW-1:0]   mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [IdxW-1:0]   op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic              op_wr;

  // Upper address bits are deliberately discarded (address wraps modulo DEPTH).
  logic unused_addr;
  assign unused_addr = ^address;

  // With LATENCY=1 the operation completes on the acceptance edge, so it uses the live inputs.
  assign op_addr  = (state_q == StIdle) ? address[IdxW-1:0] : addr_q;
  assign op_wdata = (state_q == StIdle) ? data : wdata_q;
  assign op_wr    = (state_q == StIdle) ? write : wr_q;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    enter_resp = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = op_addr;
    mem_wdata  = op_wdata;

    unique case (state_q)
      StInit: begin
        mem_we     = 1'b1;
        mem_addr   = init_cnt_q;
        mem_wdata  = '0;
        init_cnt_d = init_cnt_q + IdxW'(1);
        if (init_cnt_q == IdxW'(DEPTH - 1)) state_d = StIdle;
      end
      StIdle: begin
        if (req) begin
          addr_d     = address[IdxW-1:0];
          wdata_d    = data;
          wr_d       = write;
          wait_cnt_d = WaitW'(WaitLoad);
          if (LATENCY == 1) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (wait_cnt_q == '0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q - WaitW'(1);
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StInit;
    endcase

    if (enter_resp) mem_we = op_wr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      if (enter_resp && !op_wr) out_q <= mem[op_addr];
    end
  end

  // Reset gates the write so an aborted operation never lands in memory.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_addr] <= mem_wdata;
  end

  assign busy     = (state_q != StIdle);
  assign response = (state_q == StResp);
  assign out      = out_q;

endmodule

// File: tb/tb_param_ram.sv
// Randomized bench for param_ram against an array-based memory model.
module tb_param_ram;

  localparam int unsigned DataW   = 32;
  localparam int unsigned AddrW   = 8;
  localparam int unsigned Depth   = 16;
  localparam int unsigned Latency = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req = 1'b0;
  logic             write = 1'b0;
  logic [AddrW-1:0] address = '0;
  logic [DataW-1:0] data = '0;
  logic             busy;
  logic             response;
  logic [DataW-1:0] out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_resp = 0;
  int unsigned n_req = 0;

  logic [DataW-1:0] model_mem [Depth];
  logic [DataW-1:0] model_out;

  always #5 clk = ~clk;

  param_ram #(
    .DATA_W (DataW),
    .ADDR_W (AddrW),
    .DEPTH  (Depth),
    .LATENCY(Latency)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .write   (write),
    .address (address),
    .data    (data),
    .busy    (busy),
    .response(response),
    .out     (out)
  );

  always @(negedge clk) if (response) n_resp++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < Depth; i++) model_mem[i] = '0;
    model_out = '0;
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("init_cycles", 32'(n), 32'(Depth));
  endtask

  // Issue one request from IDLE; during the wait the bus carries wait_* values.
  task automatic do_req(input bit wr, input logic [AddrW-1:0] addr, input logic [DataW-1:0] wd,
                        input bit wait_req, input logic [AddrW-1:0] wait_addr,
                        input logic [DataW-1:0] wait_data);
    int lat;
    int busy_cycles;
    logic [3:0] idx;
    idx = addr[3:0];
    check_eq("busy_idle", 32'(busy), 32'd0);
    req = 1'b1; write = wr; address = addr; data = wd;
    @(posedge clk); #1;
    n_req++;
    req = wait_req; write = 1'b1; address = wait_addr; data = wait_data;
    lat = 1;
    busy_cycles = 0;
    while (!response && lat < 10) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    req = 1'b0;
    if (busy) busy_cycles++;
    check_eq("resp_latency", 32'(lat), 32'(Latency));
    if (wr) model_mem[idx] = wd;
    else model_out = model_mem[idx];
    check_eq("out", out, model_out);
    @(posedge clk); #1;
    check_eq("resp_one_cycle", 32'(response), 32'd0);
    check_eq("busy_released", 32'(busy), 32'd0);
    check_eq("busy_cycles", 32'(busy_cycles), 32'(Latency));
  endtask

  initial begin
    logic [AddrW-1:0] ra;
    logic [AddrW-1:0] wa;
    logic [DataW-1:0] rd;
    logic [DataW-1:0] wd;
    bit rw;
    bit rq;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", 32'(busy), 32'd1);
    check_eq("reset_response", 32'(response), 32'd0);
    check_eq("reset_out", out, 32'd0);
    reset = 1'b0;
    wait_init();

    do_req(1'b0, 8'd0, 32'h0, 1'b0, 8'd3, 32'h1);
    do_req(1'b0, 8'd7, 32'h0, 1'b0, 8'd3, 32'h1);
    do_req(1'b0, 8'd15, 32'h0, 1'b0, 8'd3, 32'h1);

    do_req(1'b1, 8'd5, 32'hDEADBEEF, 1'b0, 8'd0, 32'h0);
    do_req(1'b0, 8'd5, 32'h0, 1'b0, 8'd0, 32'h0);
    check_eq("read_deadbeef", out, 32'hDEADBEEF);

    do_req(1'b1, 8'd21, 32'h00001234, 1'b0, 8'd0, 32'h0);
    do_req(1'b0, 8'd5, 32'h0, 1'b0, 8'd0, 32'h0);
    check_eq("wrap_read", out, 32'h00001234);

    do_req(1'b1, 8'd3, 32'h0000AAAA, 1'b1, 8'd4, 32'h0000BBBB);
    check_eq("ignored_req_pulses", 32'(n_resp), 32'(n_req));
    do_req(1'b0, 8'd4, 32'h0, 1'b0, 8'd0, 32'h0);
    check_eq("addr4_untouched", out, 32'h0);
    do_req(1'b0, 8'd3, 32'h0, 1'b0, 8'd0, 32'h0);
    check_eq("addr3_written", out, 32'h0000AAAA);

    // Abort a pending write with reset.
    req = 1'b1; write = 1'b1; address = 8'd7; data = 32'h0000FFFF;
    @(posedge clk); #1;
    req = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_response", 32'(response), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd1);
    check_eq("abort_out", out, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    wait_init();
    check_eq("abort_no_pulse", 32'(n_resp), 32'(n_req));
    do_req(1'b0, 8'd7, 32'h0, 1'b0, 8'd0, 32'h0);
    check_eq("abort_no_write", out, 32'h0);

    do_req(1'b1, 8'd9, 32'h99999999, 1'b0, 8'd0, 32'h0);
    do_req(1'b1, 8'd5, 32'h55555555, 1'b0, 8'd0, 32'h0);
    do_req(1'b0, 8'd5, 32'h0, 1'b0, 8'd9, 32'h0);
    check_eq("captured_addr", out, 32'h55555555);

    for (int i = 0; i < 60; i++) begin
      rw = 1'($urandom_range(0, 1));
      rq = 1'($urandom_range(0, 1));
      ra = AddrW'($urandom);
      wa = AddrW'($urandom);
      rd = $urandom;
      wd = $urandom;
      do_req(rw, ra, rd, rq, wa, wd);
    end

    check_eq("total_pulses", 32'(n_resp), 32'(n_req));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 32, request address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 4096, number of words; power of two, at least 2.
REQ-004 The block SHALL have parameter LATENCY, default 2, cycles from acceptance to response; at least 1.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset.
REQ-006 Port clk  input  1  rising-edge clock for all state.
REQ-007 Port reset  input  1  synchronous, active-high reset.
REQ-008 Port req  input  1  request strobe, sampled only while busy is low.
REQ-009 Port write  input  1  request type: 1 = write, 0 = read.
REQ-010 Port address  input  ADDR_W  word address.
REQ-011 Port data  input  DATA_W  write data.
REQ-012 Port busy  output  1  high when the block cannot accept a request.
REQ-013 Port response  output  1  one-cycle completion pulse.
REQ-014 Port out  output  DATA_W  read data, held until the next read completes.

Function
REQ-015 The block SHALL implement four states: INIT, IDLE, WAIT and RESP.
REQ-016 busy SHALL be 1 in INIT, WAIT and RESP, and 0 only in IDLE.
REQ-017 INIT SHALL write zero to one word per cycle, addresses 0 to DEPTH-1 in order, then go to IDLE, for DEPTH cycles total.
REQ-018 A request SHALL be accepted on the rising edge where state is IDLE and req is 1.
REQ-019 On acceptance, the block SHALL capture address mod DEPTH (low log2(DEPTH) bits), data and write, and go to WAIT.
REQ-020 Input changes after acceptance SHALL have no effect on the pending operation.
REQ-021 WAIT SHALL last LATENCY-1 cycles, counted by a down-counter; with LATENCY=1, WAIT lasts zero cycles and the block goes directly to RESP.
REQ-022 response SHALL be 1 for exactly the one cycle in RESP, which begins LATENCY edges after the acceptance edge.
REQ-023 On the edge entering RESP, a write SHALL update the memory word and a read SHALL load out with the stored word.
REQ-024 On a write, out SHALL keep its previous value.
REQ-025 RESP SHALL always go to IDLE on the next edge; req during RESP, WAIT or INIT SHALL be ignored and not queued.
REQ-026 Maximum throughput SHALL be one request per LATENCY+1 cycles.
REQ-027 A read following a completed write to the same address SHALL return the written data.
REQ-028 A request SHALL receive exactly one response pulse, and response SHALL never assert without an accepted request.
REQ-029 The init and wait counters SHALL be sized by clog2 of DEPTH and LATENCY, and SHALL wrap neither early nor late.

Reset
REQ-030 While reset is 1, state SHALL be INIT, the init counter 0, busy 1, response 0 and out 0.
REQ-031 Reset asserted in WAIT or RESP SHALL abort the pending operation: no memory update, no response pulse.
REQ-032 After reset deasserts, the block SHALL run the full INIT sweep before accepting any request.

Verification (DEPTH=16, LATENCY=2, DATA_W=32)
REQ-033 Release reset -> busy high for exactly 16 cycles, then low; a read of addresses 0, 7 and 15 returns 0x00000000.
REQ-034 Write 0xDEADBEEF to address 5, then read address 5 -> each response pulse occurs 2 edges after acceptance; read out = 0xDEADBEEF; busy is high for 2 cycles per request.
REQ-035 Write 0x00001234 to address 21 -> a read of address 5 returns 0x00001234 (wrap modulo 16).
REQ-036 Accept a write of 0x0000AAAA to address 3; during WAIT drive req=1, write=1, address=4, data=0x0000BBBB -> only one response pulse; address 4 reads 0; address 3 reads 0x0000AAAA.
REQ-037 Accept a write of 0x0000FFFF to address 7; assert reset during WAIT -> no response pulse; after INIT, address 7 reads 0.
REQ-038 Accept a read of address 5, then change address to 9 on the next cycle -> out is the value stored at address 5.
